// File: rtl/cache_pkg.sv
// Shared types for the two-way cache controller: FSM state encoding and
// performance counter width.
package cache_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    MEM_REQ,
    MEM_WAIT,
    FILL,
    RESP
  } cache_ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc_i and holds at all-ones.
module sat_counter
  import cache_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/two_way_cache_controller.sv
// Single-outstanding cache controller: read-allocate, write-through/no-allocate.
// Optional hit/miss counters are compiled in with CACHE_PERF_COUNTERS_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | ready for a CPU request (once out of reset)
// LOOKUP   | probe cache with latched address; read hit answers here
// MEM_REQ  | present read/write to memory until mem_req_ready
// MEM_WAIT | wait for mem_resp_valid
// FILL     | write fill register into cache for one cycle
// RESP     | one-cycle CPU response for misses and writes
module two_way_cache_controller
  import cache_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req_valid,
  output logic                  cpu_req_ready,
  input  logic [ADDR_SIZE-1:0]  cpu_req_addr,
  input  logic                  cpu_req_we,
  input  logic [BLOCK_SIZE-1:0] cpu_req_wdata,
  output logic                  cpu_resp_valid,
  output logic [BLOCK_SIZE-1:0] cpu_resp_rdata,
  output logic [ADDR_SIZE-1:0]  cache_addr,
  output logic                  cache_we,
  output logic [BLOCK_SIZE-1:0] cache_wdata,
  input  logic [BLOCK_SIZE-1:0] cache_rdata,
  input  logic                  cache_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_SIZE-1:0]  mem_req_addr,
  output logic                  mem_req_we,
  output logic [BLOCK_SIZE-1:0] mem_req_wdata,
  input  logic                  mem_resp_valid,
  input  logic [BLOCK_SIZE-1:0] mem_resp_rdata
`ifdef CACHE_PERF_COUNTERS_EN
  ,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
`endif
);

  cache_ctrl_state_t     state_q;
  logic [ADDR_SIZE-1:0]  addr_q;
  logic                  we_q;
  logic [BLOCK_SIZE-1:0] wdata_q;
  logic [BLOCK_SIZE-1:0] fill_q;
  logic                  live_q;

  // live_q keeps ready low while in reset and lets it rise one cycle after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      fill_q  <= '0;
      live_q  <= 1'b0;
    end else begin
      live_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cpu_req_valid && live_q) begin
            addr_q  <= cpu_req_addr;
            we_q    <= cpu_req_we;
            wdata_q <= cpu_req_wdata;
            state_q <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (!we_q && cache_hit) state_q <= IDLE;
          else                    state_q <= MEM_REQ;
        end
        MEM_REQ: begin
          if (mem_req_ready) state_q <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_resp_valid) begin
            if (we_q) begin
              state_q <= RESP;
            end else begin
              fill_q  <= mem_resp_rdata;
              state_q <= FILL;
            end
          end
        end
        FILL:    state_q <= RESP;
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Hit response and write-hit update depend on cache_hit in the same cycle.
  always_comb begin
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    cpu_resp_rdata = '0;
    cache_addr     = '0;
    cache_we       = 1'b0;
    cache_wdata    = '0;
    mem_req_valid  = 1'b0;
    mem_req_addr   = '0;
    mem_req_we     = 1'b0;
    mem_req_wdata  = '0;
    case (state_q)
      IDLE: cpu_req_ready = live_q;
      LOOKUP: begin
        cache_addr = addr_q;
        if (cache_hit) begin
          if (we_q) begin
            cache_we    = 1'b1;
            cache_wdata = wdata_q;
          end else begin
            cpu_resp_valid = 1'b1;
            cpu_resp_rdata = cache_rdata;
          end
        end
      end
      MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = addr_q;
        mem_req_we    = we_q;
        mem_req_wdata = we_q ? wdata_q : '0;
      end
      FILL: begin
        cache_we    = 1'b1;
        cache_addr  = addr_q;
        cache_wdata = fill_q;
      end
      RESP: begin
        cpu_resp_valid = 1'b1;
        cpu_resp_rdata = we_q ? '0 : fill_q;
      end
      default: ;
    endcase
  end

`ifdef CACHE_PERF_COUNTERS_EN
  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   ((state_q == LOOKUP) && cache_hit),
    .count_o (hit_count)
  );

  sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   ((state_q == LOOKUP) && !cache_hit),
    .count_o (miss_count)
  );
`endif

endmodule

// File: tb/tb_two_way_cache_controller.sv
// Randomized bench for two_way_cache_controller with cache/memory device models
// and an address-level reference of cache contents and memory values.
module tb_two_way_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req_valid = 1'b0;
  logic        cpu_req_ready;
  logic [31:0] cpu_req_addr = '0;
  logic        cpu_req_we = 1'b0;
  logic [31:0] cpu_req_wdata = '0;
  logic        cpu_resp_valid;
  logic [31:0] cpu_resp_rdata;
  logic [31:0] cache_addr;
  logic        cache_we;
  logic [31:0] cache_wdata;
  logic [31:0] cache_rdata;
  logic        cache_hit;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_we;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
`ifdef CACHE_PERF_COUNTERS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  always #5 clk = ~clk;

  two_way_cache_controller dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_req_addr   (cpu_req_addr),
    .cpu_req_we     (cpu_req_we),
    .cpu_req_wdata  (cpu_req_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_resp_rdata (cpu_resp_rdata),
    .cache_addr     (cache_addr),
    .cache_we       (cache_we),
    .cache_wdata    (cache_wdata),
    .cache_rdata    (cache_rdata),
    .cache_hit      (cache_hit),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_we     (mem_req_we),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_rdata (mem_resp_rdata)
`ifdef CACHE_PERF_COUNTERS_EN
    ,
    .hit_count      (hit_count),
    .miss_count     (miss_count)
`endif
  );

  // Bench-side controls
  logic        pl_en = 1'b0;
  logic        pl_mem_en = 1'b0;
  logic [2:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;
  logic        bp_hold = 1'b0;
  int          lat_cfg = 0;

  // Cache array device: line i lives at address i*0x100
  logic        dev_cvalid [8] = '{default: 1'b0};
  logic [31:0] dev_cdata  [8] = '{default: 32'h0};
  logic [2:0]  cidx;
  int          cwe_cnt = 0;

  assign cidx        = cache_addr[10:8];
  assign cache_hit   = dev_cvalid[cidx] && (cache_addr[7:0] == 8'h0) && (cache_addr[31:11] == 21'h0);
  assign cache_rdata = dev_cdata[cidx];

  always @(posedge clk) begin
    if (pl_en) begin
      dev_cvalid[pl_idx] <= 1'b1;
      dev_cdata[pl_idx]  <= pl_data;
    end
    if (cache_we) begin
      dev_cvalid[cidx] <= 1'b1;
      dev_cdata[cidx]  <= cache_wdata;
      cwe_cnt          <= cwe_cnt + 1;
    end
  end

  // Memory device: random ready, programmable latency, spurious resp pulses while idle
  logic [31:0] dev_mem [8] = '{default: 32'h0};
  logic        m_busy;
  int          m_lat;
  logic [2:0]  m_idx;
  logic        rdy_rand;
  int          hs_cnt = 0;

  assign mem_req_ready = rdy_rand & ~bp_hold;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy         <= 1'b0;
      m_lat          <= 0;
      m_idx          <= '0;
      rdy_rand       <= 1'b0;
      mem_resp_valid <= 1'b0;
      mem_resp_rdata <= '0;
    end else begin
      rdy_rand       <= ($urandom_range(0, 3) != 0);
      mem_resp_valid <= 1'b0;
      mem_resp_rdata <= $urandom;
      if (pl_mem_en) dev_mem[pl_idx] <= pl_data;
      if (!m_busy) begin
        if (mem_req_valid && mem_req_ready) begin
          m_busy <= 1'b1;
          m_lat  <= lat_cfg;
          m_idx  <= mem_req_addr[10:8];
          hs_cnt <= hs_cnt + 1;
          if (mem_req_we) dev_mem[mem_req_addr[10:8]] <= mem_req_wdata;
        end else if ($urandom_range(0, 7) == 0) begin
          mem_resp_valid <= 1'b1;
        end
      end else if (m_lat == 0) begin
        mem_resp_valid <= 1'b1;
        mem_resp_rdata <= dev_mem[m_idx];
        m_busy         <= 1'b0;
      end else begin
        m_lat <= m_lat - 1;
      end
    end
  end

  // Response pulse counter and memory-request stability monitor
  int          resp_cnt = 0;
  int          hold_viol = 0;
  logic        prev_pend = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_we = 1'b0;

  always @(posedge clk) begin
    if (cpu_resp_valid) resp_cnt <= resp_cnt + 1;
    if (!rst) begin
      prev_pend <= 1'b0;
    end else begin
      if (prev_pend && (!mem_req_valid || mem_req_addr != prev_addr || mem_req_we != prev_we))
        hold_viol <= hold_viol + 1;
      prev_pend <= mem_req_valid && !mem_req_ready;
      prev_addr <= mem_req_addr;
      prev_we   <= mem_req_we;
    end
  end

  // Reference model: which lines are cached and what memory holds
  logic        model_valid [8];
  logic [31:0] model_mem   [8];
  int          model_hits = 0;
  int          model_misses = 0;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input bit we, input int idx, input logic [31:0] wdata, input bit bp);
    int          cyc;
    int          lat;
    int          r0, h0, c0;
    int          busy_rdy;
    int          bp_bad;
    bit          got;
    bit          exp_hit;
    logic [31:0] exp_rd;
    logic [31:0] rdata;
    exp_hit = model_valid[idx];
    exp_rd  = we ? 32'h0 : model_mem[idx];
    @(negedge clk);
    cyc = 0;
    while (!cpu_req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!cpu_req_ready) begin
      chk("ready_timeout", cpu_req_ready, 1);
      return;
    end
    r0 = resp_cnt;
    h0 = hs_cnt;
    c0 = cwe_cnt;
    if (bp) bp_hold = 1'b1;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = idx << 8;
    cpu_req_we    = we;
    cpu_req_wdata = wdata;
    @(posedge clk);
    #1;
    cpu_req_valid = 1'b0;
    cpu_req_addr  = $urandom;
    cpu_req_we    = $urandom_range(0, 1) == 1;
    cpu_req_wdata = $urandom;
    lat = 0; got = 0; busy_rdy = 0; bp_bad = 0; rdata = '0;
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (cpu_req_ready) busy_rdy++;
      if (bp && lat >= 2 && lat <= 6)
        if (!mem_req_valid || mem_req_addr != (idx << 8) || mem_req_we != we) bp_bad++;
      if (bp && lat == 6) bp_hold = 1'b0;
      if (cpu_resp_valid) begin
        got   = 1;
        rdata = cpu_resp_rdata;
      end
    end
    bp_hold = 1'b0;
    chk("resp_seen", got, 1);
    if (got) chk("resp_rdata", rdata, exp_rd);
    @(negedge clk);
    chk("resp_pulses", resp_cnt - r0, 1);
    chk("mem_reqs", hs_cnt - h0, (we || !exp_hit) ? 1 : 0);
    chk("cache_we_pulses", cwe_cnt - c0, we ? (exp_hit ? 1 : 0) : (exp_hit ? 0 : 1));
    chk("ready_while_busy", busy_rdy, 0);
    if (!we && exp_hit) chk("hit_latency", lat, 1);
    if (bp) chk("bp_stable", bp_bad, 0);
    if (we) model_mem[idx] = wdata;
    else if (!exp_hit) model_valid[idx] = 1'b1;
    if (exp_hit) model_hits++;
    else model_misses++;
  endtask

  initial begin
    int          cyc;
    int          r0, h0;
    logic [31:0] d;
    for (int i = 0; i < 8; i++) model_valid[i] = 1'b0;
    #1;
    chk("reset_ready", cpu_req_ready, 0);
    chk("reset_outputs", |{cpu_resp_valid, cpu_resp_rdata, cache_addr, cache_we, cache_wdata,
                           mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("release_ready_low", cpu_req_ready, 0);
    @(negedge clk);
    chk("release_ready_high", cpu_req_ready, 1);

    for (int i = 0; i < 8; i++) begin
      d = (i == 1) ? 32'hDEADBEEF : (i == 2) ? 32'h12345678 : $urandom;
      model_mem[i] = d;
      pl_mem_en = 1'b1;
      pl_en     = (i == 1);
      pl_idx    = 3'(i);
      pl_data   = d;
      @(negedge clk);
    end
    pl_mem_en = 1'b0;
    pl_en     = 1'b0;
    model_valid[1] = 1'b1;

    lat_cfg = 2;
    do_req(0, 1, 32'h0, 0);
    lat_cfg = 3;
    do_req(0, 2, 32'h0, 0);
    do_req(0, 2, 32'h0, 0);
    do_req(1, 1, 32'hCAFEF00D, 0);
    do_req(0, 1, 32'h0, 0);
    lat_cfg = 1;
    do_req(0, 3, 32'h0, 1);

    for (int t = 0; t < 40; t++) begin
      lat_cfg = $urandom_range(0, 4);
      do_req($urandom_range(0, 2) == 0, $urandom_range(0, 5), $urandom, $urandom_range(0, 7) == 0);
    end

    // Reset while waiting on memory for a read miss of line 6
    lat_cfg = 10;
    @(negedge clk);
    cyc = 0;
    while (!cpu_req_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    r0 = resp_cnt;
    h0 = hs_cnt;
    cpu_req_valid = 1'b1;
    cpu_req_addr  = 32'h600;
    cpu_req_we    = 1'b0;
    @(posedge clk);
    #1 cpu_req_valid = 1'b0;
    cyc = 0;
    while (hs_cnt == h0 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_test_mem_hs", hs_cnt - h0, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("midrst_ready", cpu_req_ready, 0);
    chk("midrst_outputs", |{cpu_resp_valid, cpu_resp_rdata, cache_addr, cache_we, cache_wdata,
                            mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata}, 0);
`ifdef CACHE_PERF_COUNTERS_EN
    chk("midrst_counters", {hit_count, miss_count}, 0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("midrst_release_ready_low", cpu_req_ready, 0);
    repeat (15) @(negedge clk);
    chk("midrst_no_resp", resp_cnt - r0, 0);
    model_hits   = 0;
    model_misses = 0;
    lat_cfg = 3;

    do_req(0, 1, 32'h0, 0);
    do_req(0, 7, 32'h0, 0);
    do_req(0, 7, 32'h0, 0);
`ifdef CACHE_PERF_COUNTERS_EN
    chk("hit_count", hit_count, 2);
    chk("miss_count", miss_count, 1);
    chk("model_hits", hit_count, model_hits);
`endif

    for (int i = 0; i < 8; i++) begin
      chk("final_mem", dev_mem[i], model_mem[i]);
      chk("final_cvalid", dev_cvalid[i], model_valid[i]);
      if (model_valid[i]) chk("final_cdata", dev_cdata[i], model_mem[i]);
    end
    chk("mem_hold_violations", hold_viol, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/two_way_cache_controller.md
TWO_WAY_CACHE_CONTROLLER -- requirements
Module: two_way_cache_controller

Interface
REQ-001 Parameters SHALL be: ADDR_SIZE, 32, address width; BLOCK_SIZE, 32, data block width in bits.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 cpu_req_valid / cpu_req_ready  input / output  1 each  CPU request handshake.
REQ-005 cpu_req_addr  input  ADDR_SIZE; cpu_req_we  input  1; cpu_req_wdata  input  BLOCK_SIZE.
REQ-006 cpu_resp_valid  output  1  one-cycle pulse; cpu_resp_rdata  output  BLOCK_SIZE.
REQ-007 cache_addr  output  ADDR_SIZE; cache_we  output  1; cache_wdata  output  BLOCK_SIZE; cache_rdata  input  BLOCK_SIZE; cache_hit  input  1 (combinational from cache_addr).
REQ-008 mem_req_valid / mem_req_ready  output / input  1 each; mem_req_addr  output  ADDR_SIZE; mem_req_we  output  1; mem_req_wdata  output  BLOCK_SIZE.
REQ-009 mem_resp_valid  input  1; mem_resp_rdata  input  BLOCK_SIZE.

Function
REQ-010 FSM states SHALL be IDLE, LOOKUP, MEM_REQ, MEM_WAIT, FILL, RESP.
REQ-011 IDLE: cpu_req_ready=1; on valid&ready latch addr/we/wdata into request registers, go LOOKUP; ready=0 in all other states.
REQ-012 LOOKUP: cache_addr=latched addr; read hit -> cpu_resp_valid=1, cpu_resp_rdata=cache_rdata same cycle, go IDLE (hit latency 1 cycle after accept).
REQ-013 LOOKUP read miss -> MEM_REQ with mem_req_we=0.
REQ-014 LOOKUP write: write-through, no-allocate; on hit cache_we=1, cache_wdata=latched wdata this cycle; hit or miss -> MEM_REQ with mem_req_we=1.
REQ-015 MEM_REQ: mem_req_valid=1, addr/we/wdata stable until mem_req_ready sampled 1; then MEM_WAIT.
REQ-016 MEM_WAIT: mem_resp_valid sampled only here; read -> capture mem_resp_rdata into fill register, go FILL; write -> go RESP.
REQ-017 FILL: cache_we=1, cache_addr=latched addr, cache_wdata=fill register for exactly one cycle; go RESP.
REQ-018 RESP: cpu_resp_valid=1 one cycle; rdata=fill register for reads, zero for writes; go IDLE.
REQ-019 cache_we SHALL be 0 outside LOOKUP-write-hit and FILL; mem_req_valid SHALL be 0 outside MEM_REQ.
REQ-020 mem_resp_valid outside MEM_WAIT (incl. same cycle as mem_req_ready) SHALL be ignored.
REQ-021 cpu_req_valid while busy SHALL not be accepted; requester holds it.
REQ-022 Exactly one outstanding request; no reordering.

Reset
REQ-023 rst low SHALL asynchronously force IDLE and clear request, fill and counter registers.
REQ-024 During reset all outputs SHALL be 0 except cpu_req_ready=0; ready rises first cycle after release.
REQ-025 Reset mid-transaction SHALL drop the request with no cpu_resp_valid; a partially handshaken memory transaction is the memory's responsibility.

Configuration
REQ-026 Macro CACHE_PERF_COUNTERS_EN defined: outputs hit_count and miss_count (32 bits each) added; counting each LOOKUP hit/miss, saturating at all-ones.
REQ-027 Macro undefined: those ports and registers SHALL not exist; behaviour otherwise identical.

Structure
REQ-028 Shared package cache_pkg SHALL hold the state enum cache_ctrl_state_t and counter width constant.
REQ-029 Optional sub-module sat_counter (saturating increment) SHALL be used for perf counters; FSM stays in this module.

Verification
REQ-030 Read hit: preload 0x100=0xDEADBEEF; read 0x100 -> cpu_resp_valid one cycle after accept, rdata 0xDEADBEEF, no mem_req_valid.
REQ-031 Read miss: read 0x200, memory returns 0x12345678 after 3 cycles -> one cache_we pulse at 0x200, resp rdata 0x12345678; repeat read hits.
REQ-032 Write hit: write 0xCAFEF00D to cached 0x100 -> cache_we in LOOKUP, mem write issued, resp rdata 0; later read returns 0xCAFEF00D.
REQ-033 Backpressure: mem_req_ready low 5 cycles -> mem_req_valid/addr held stable; cpu_req_ready stays 0; one response only.
REQ-034 Reset mid-MEM_WAIT: assert rst -> outputs 0 immediately, no response; next request served normally.
REQ-035 With CACHE_PERF_COUNTERS_EN: sequence hit, miss, hit -> hit_count=2, miss_count=1.
